// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller and fixed-priority arbiter
//
// Shares the byte-wide RAM/IO port between the instruction fetcher (32-bit reads),
// the load/store buffer (1/2/4-byte loads, optional sign extension) and ROB store
// commit (1/2/4-byte stores). Each requester has a one-deep pending slot; in IDLE
// the store slot wins over the load slot, which wins over the fetch slot.
// Assembled data is designed for DATA_WIDTH = 32 (four byte lanes).
//
// Ports:
//   clk, rst, rdy            clock, sync active-high reset, global enable
//   in_rob_misbranch         flush of fetch/load work (stores unaffected)
//   in_fetcher_*/out_fetcher_*  fetch request pulse + address / done pulse + word
//   in_lsb_*/out_lsb_*       load request (size, signed, address) / done pulse + data
//   in_rob_*/out_rob_ce      store request (size, address, data) / done pulse
//   mem_din, io_buffer_full  RAM/IO read byte, IO write back-pressure
//   mem_dout, mem_a, mem_wr  write byte, byte address, write strobe
module mem_ctrl #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] IO_SEL     = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_rob_misbranch,
    input  logic                  in_fetcher_ce,
    input  logic [DATA_WIDTH-1:0] in_fetcher_addr,
    output logic                  out_fetcher_ce,
    output logic [DATA_WIDTH-1:0] out_fetcher_data,
    input  logic                  in_lsb_ce,
    input  logic [5:0]            in_lsb_size,
    input  logic                  in_lsb_signed,
    input  logic [DATA_WIDTH-1:0] in_lsb_addr,
    output logic                  out_lsb_ce,
    output logic [DATA_WIDTH-1:0] out_lsb_data,
    input  logic                  in_rob_ce,
    input  logic [5:0]            in_rob_size,
    input  logic [DATA_WIDTH-1:0] in_rob_addr,
    input  logic [DATA_WIDTH-1:0] in_rob_data,
    output logic                  out_rob_ce,
    input  logic [7:0]            mem_din,
    input  logic                  io_buffer_full,
    output logic [7:0]            mem_dout,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t r_state, w_state_next;

    // Pending slots
    logic                  r_f_pend, r_l_pend, r_s_pend;
    logic [DATA_WIDTH-1:0] r_f_addr, r_l_addr, r_s_addr, r_s_data;
    logic [5:0]            r_l_size, r_s_size;
    logic                  r_l_signed;

    // Active transaction
    logic [DATA_WIDTH-1:0] r_addr, r_mem_a, r_prev_a;
    logic [NB-1:0][7:0]    r_data, r_buf;
    logic [2:0]            r_n, r_cnt;
    logic                  r_is_fetch, r_signed;
    logic [7:0]            r_mem_dout;

    // A pulse in the current cycle overrides its slot, so it can be granted at once
    logic                  w_f_valid, w_l_valid, w_s_valid;
    logic [DATA_WIDTH-1:0] w_f_addr, w_l_addr, w_s_addr, w_s_data;
    logic [5:0]            w_l_size, w_s_size;
    logic                  w_l_signed;
    logic                  w_grant_f, w_grant_l, w_grant_s;
    logic                  w_stall, w_read_last, w_write_last;
    logic [1:0]            w_byte_idx, w_next_idx;
    logic [NB-1:0][7:0]    w_word;
    logic [DATA_WIDTH-1:0] w_ext;

    function automatic logic [2:0] size_to_n(input logic [5:0] s);
        case (s)
            6'd1:    return 3'd1;
            6'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign w_f_valid  = !in_rob_misbranch && (in_fetcher_ce || r_f_pend);
    assign w_l_valid  = !in_rob_misbranch && (in_lsb_ce || r_l_pend);
    assign w_s_valid  = in_rob_ce || r_s_pend;
    assign w_f_addr   = in_fetcher_ce ? in_fetcher_addr : r_f_addr;
    assign w_l_addr   = in_lsb_ce ? in_lsb_addr : r_l_addr;
    assign w_l_size   = in_lsb_ce ? in_lsb_size : r_l_size;
    assign w_l_signed = in_lsb_ce ? in_lsb_signed : r_l_signed;
    assign w_s_addr   = in_rob_ce ? in_rob_addr : r_s_addr;
    assign w_s_size   = in_rob_ce ? in_rob_size : r_s_size;
    assign w_s_data   = in_rob_ce ? in_rob_data : r_s_data;

    assign w_grant_s = (r_state == S_IDLE) && w_s_valid;
    assign w_grant_l = (r_state == S_IDLE) && !w_s_valid && w_l_valid;
    assign w_grant_f = (r_state == S_IDLE) && !w_s_valid && !w_l_valid && w_f_valid;

    assign w_stall      = (r_addr[17:16] == IO_SEL) && io_buffer_full;
    assign w_read_last  = (r_cnt == r_n);
    assign w_write_last = (r_cnt == r_n - 3'd1);
    // In READ, the byte arriving on mem_din belongs to the address issued last cycle
    assign w_byte_idx   = r_cnt[1:0] - 2'd1;
    assign w_next_idx   = r_cnt[1:0] + 2'd1;

    // A held write strobe during rdy low would repeat the write (harmful for IO)
    assign mem_wr   = (r_state == S_WRITE) && rdy && !w_stall;
    assign mem_dout = r_mem_dout;
    // While stalled, keep re-reading the last address actually issued so that
    // mem_din still carries the expected byte in the first cycle after rdy returns.
    assign mem_a    = rdy ? r_mem_a : r_prev_a;

    always_comb begin
        w_word             = r_buf;
        w_word[w_byte_idx] = mem_din;
    end

    always_comb begin
        w_ext = w_word;
        case (r_n)
            3'd1:    w_ext = {{24{r_signed & w_word[0][7]}}, w_word[0]};
            3'd2:    w_ext = {{16{r_signed & w_word[1][7]}}, w_word[1], w_word[0]};
            default: w_ext = w_word;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_s)                   w_state_next = S_WRITE;
                else if (w_grant_l || w_grant_f) w_state_next = S_READ;
            end
            S_READ:  if (in_rob_misbranch || w_read_last) w_state_next = S_IDLE;
            S_WRITE: if (!w_stall && w_write_last)        w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_f_pend         <= 1'b0;
            r_l_pend         <= 1'b0;
            r_s_pend         <= 1'b0;
            r_f_addr         <= '0;
            r_l_addr         <= '0;
            r_s_addr         <= '0;
            r_s_data         <= '0;
            r_l_size         <= '0;
            r_s_size         <= '0;
            r_l_signed       <= 1'b0;
            r_addr           <= '0;
            r_mem_a          <= '0;
            r_prev_a         <= '0;
            r_data           <= '0;
            r_buf            <= '0;
            r_n              <= '0;
            r_cnt            <= '0;
            r_is_fetch       <= 1'b0;
            r_signed         <= 1'b0;
            r_mem_dout       <= '0;
            out_fetcher_ce   <= 1'b0;
            out_fetcher_data <= '0;
            out_lsb_ce       <= 1'b0;
            out_lsb_data     <= '0;
            out_rob_ce       <= 1'b0;
        end else if (rdy) begin
            r_state        <= w_state_next;
            r_prev_a       <= r_mem_a;
            out_fetcher_ce <= 1'b0;
            out_lsb_ce     <= 1'b0;
            out_rob_ce     <= 1'b0;

            if (in_rob_misbranch || w_grant_f) r_f_pend <= 1'b0;
            else if (in_fetcher_ce) begin
                r_f_pend <= 1'b1;
                r_f_addr <= in_fetcher_addr;
            end
            if (in_rob_misbranch || w_grant_l) r_l_pend <= 1'b0;
            else if (in_lsb_ce) begin
                r_l_pend   <= 1'b1;
                r_l_addr   <= in_lsb_addr;
                r_l_size   <= in_lsb_size;
                r_l_signed <= in_lsb_signed;
            end
            if (w_grant_s) r_s_pend <= 1'b0;
            else if (in_rob_ce) begin
                r_s_pend <= 1'b1;
                r_s_addr <= in_rob_addr;
                r_s_size <= in_rob_size;
                r_s_data <= in_rob_data;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_grant_s) begin
                        r_addr     <= w_s_addr;
                        r_n        <= size_to_n(w_s_size);
                        r_data     <= w_s_data;
                        r_mem_a    <= w_s_addr;
                        r_mem_dout <= w_s_data[7:0];
                    end else if (w_grant_l) begin
                        r_addr     <= w_l_addr;
                        r_n        <= size_to_n(w_l_size);
                        r_signed   <= w_l_signed;
                        r_is_fetch <= 1'b0;
                        r_mem_a    <= w_l_addr;
                    end else if (w_grant_f) begin
                        r_addr     <= w_f_addr;
                        r_n        <= 3'd4;
                        r_signed   <= 1'b0;
                        r_is_fetch <= 1'b1;
                        r_mem_a    <= w_f_addr;
                    end
                end
                S_READ: begin
                    if (!in_rob_misbranch) begin
                        if (r_cnt != 3'd0) r_buf[w_byte_idx] <= mem_din;
                        if (w_read_last) begin
                            if (r_is_fetch) begin
                                out_fetcher_ce   <= 1'b1;
                                out_fetcher_data <= w_word;
                            end else begin
                                out_lsb_ce   <= 1'b1;
                                out_lsb_data <= w_ext;
                            end
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt + 3'd1 < r_n)
                                r_mem_a <= r_addr + DATA_WIDTH'(r_cnt + 3'd1);
                        end
                    end
                end
                S_WRITE: begin
                    if (!w_stall) begin
                        if (w_write_last) out_rob_ce <= 1'b1;
                        else begin
                            r_cnt      <= r_cnt + 3'd1;
                            r_mem_a    <= r_addr + DATA_WIDTH'(r_cnt + 3'd1);
                            r_mem_dout <= r_data[w_next_idx];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with RAM model and reference memory
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, in_rob_misbranch;
    logic        in_fetcher_ce, out_fetcher_ce;
    logic [31:0] in_fetcher_addr, out_fetcher_data;
    logic        in_lsb_ce, in_lsb_signed, out_lsb_ce;
    logic [5:0]  in_lsb_size, in_rob_size;
    logic [31:0] in_lsb_addr, out_lsb_data;
    logic        in_rob_ce, out_rob_ce;
    logic [31:0] in_rob_addr, in_rob_data;
    logic [7:0]  mem_din, mem_dout;
    logic        io_buffer_full, mem_wr;
    logic [31:0] mem_a;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_rob_misbranch(in_rob_misbranch),
        .in_fetcher_ce(in_fetcher_ce), .in_fetcher_addr(in_fetcher_addr),
        .out_fetcher_ce(out_fetcher_ce), .out_fetcher_data(out_fetcher_data),
        .in_lsb_ce(in_lsb_ce), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
        .in_lsb_addr(in_lsb_addr), .out_lsb_ce(out_lsb_ce), .out_lsb_data(out_lsb_data),
        .in_rob_ce(in_rob_ce), .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr),
        .in_rob_data(in_rob_data), .out_rob_ce(out_rob_ce),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    logic [7:0]  ram     [0:262143];
    logic [7:0]  ref_mem [0:262143];
    logic [39:0] wlog[$];
    logic [5:0]  size_tab [4] = '{6'd1, 6'd2, 6'd4, 6'd3};
    int checks = 0, errors = 0;
    int n_f, n_l, n_r, t_f, t_l, t_r;

    // RAM with one-cycle read latency; every write is logged
    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) begin
            ram[mem_a[17:0]] = mem_dout;
            wlog.push_back({mem_a, mem_dout});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    function automatic int eff_n(input logic [5:0] sz);
        return (sz == 6'd1) ? 1 : (sz == 6'd2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n, input bit sg);
        longint v;
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[int'(a[17:0]) + k]) << (8 * k);
        if (sg && n < 4 && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input int n);
        for (int k = 0; k < n; k++) ref_mem[int'(a[17:0]) + k] = 8'((d >> (8 * k)) & 32'hFF);
    endtask

    task automatic chk_wlog(input logic [31:0] a, input logic [31:0] d, input int n);
        chk("wlog_len", wlog.size(), n);
        for (int k = 0; k < n && k < wlog.size(); k++) begin
            chk("wlog_addr", wlog[k][39:8], a + k);
            chk("wlog_byte", {24'd0, wlog[k][7:0]}, (d >> (8 * k)) & 32'hFF);
        end
    endtask

    task automatic clr_mon();
        n_f = 0; n_l = 0; n_r = 0; t_f = -1; t_l = -1; t_r = -1;
    endtask

    task automatic step_mon(input int c);
        tick();
        if (out_fetcher_ce) begin n_f++; t_f = c; end
        if (out_lsb_ce)     begin n_l++; t_l = c; end
        if (out_rob_ce)     begin n_r++; t_r = c; end
    endtask

    task automatic run_read(input bit is_f, input logic [31:0] a, input logic [5:0] sz,
                            input logic sg, output logic [31:0] d, output int lat);
        if (is_f) begin
            in_fetcher_ce = 1; in_fetcher_addr = a;
        end else begin
            in_lsb_ce = 1; in_lsb_addr = a; in_lsb_size = sz; in_lsb_signed = sg;
        end
        lat = 0;
        do begin
            tick();
            in_fetcher_ce = 0; in_lsb_ce = 0;
            lat++;
        end while (!(is_f ? out_fetcher_ce : out_lsb_ce) && lat < 30);
        d = is_f ? out_fetcher_data : out_lsb_data;
    endtask

    task automatic run_write(input logic [31:0] a, input logic [5:0] sz,
                             input logic [31:0] d, output int lat);
        wlog.delete();
        in_rob_ce = 1; in_rob_addr = a; in_rob_size = sz; in_rob_data = d;
        lat = 0;
        do begin
            tick();
            in_rob_ce = 0;
            lat++;
        end while (!out_rob_ce && lat < 30);
    endtask

    initial begin
        logic [31:0] d, a;
        logic [5:0]  sz;
        int          lat, n, op;
        bit          sg;

        for (int i = 0; i < 262144; i++) poke(i, 8'($urandom));
        rst = 1; rdy = 1; in_rob_misbranch = 0; io_buffer_full = 0;
        in_fetcher_ce = 0; in_fetcher_addr = 0; in_lsb_ce = 0; in_lsb_size = 0;
        in_lsb_signed = 0; in_lsb_addr = 0; in_rob_ce = 0; in_rob_size = 0;
        in_rob_addr = 0; in_rob_data = 0;
        repeat (3) tick();
        rst = 0;
        chk("rst_fetch_ce", out_fetcher_ce, 0);
        chk("rst_lsb_ce", out_lsb_ce, 0);
        chk("rst_rob_ce", out_rob_ce, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_lsb_data", out_lsb_data, 0);

        // Fetch
        poke(32'h10, 8'h13); poke(32'h11, 8'h05); poke(32'h12, 8'h00); poke(32'h13, 8'h00);
        run_read(1, 32'h10, 0, 0, d, lat);
        chk("fetch_lat", lat, 6);
        chk("fetch_data", d, 32'h00000513);
        tick();
        chk("fetch_pulse_len", out_fetcher_ce, 0);

        // Byte / half loads with extension
        poke(32'h100, 8'h80); poke(32'h104, 8'hFF); poke(32'h105, 8'h7F);
        run_read(0, 32'h100, 6'd1, 1, d, lat);
        chk("lb_lat", lat, 3);
        chk("lb_data", d, 32'hFFFFFF80);
        run_read(0, 32'h100, 6'd1, 0, d, lat);
        chk("lbu_data", d, 32'h00000080);
        run_read(0, 32'h104, 6'd2, 1, d, lat);
        chk("lh_lat", lat, 4);
        chk("lh_data", d, 32'h00007FFF);
        tick();
        chk("lsb_pulse_len", out_lsb_ce, 0);

        // Store, load and fetch requested together
        wlog.delete(); clr_mon();
        in_rob_ce = 1; in_rob_addr = 32'h200; in_rob_size = 4; in_rob_data = 32'hDEADBEEF;
        in_lsb_ce = 1; in_lsb_addr = 32'h200; in_lsb_size = 4; in_lsb_signed = 0;
        in_fetcher_ce = 1; in_fetcher_addr = 32'h10;
        for (int c = 1; c <= 25; c++) begin
            step_mon(c);
            in_rob_ce = 0; in_lsb_ce = 0; in_fetcher_ce = 0;
        end
        chk_wlog(32'h200, 32'hDEADBEEF, 4);
        model_store(32'h200, 32'hDEADBEEF, 4);
        chk("prio_rob_t", t_r, 5);
        chk("prio_lsb_t", t_l, 11);
        chk("prio_fetch_t", t_f, 17);
        chk("prio_counts", {n_r[7:0], n_l[7:0], n_f[7:0]}, 24'h010101);
        chk("prio_lsb_data", out_lsb_data, ref_read(32'h200, 4, 0));
        chk("prio_fetch_data", out_fetcher_data, 32'h00000513);

        // IO store stalled by a full output buffer
        wlog.delete();
        in_rob_ce = 1; in_rob_addr = 32'h30000; in_rob_size = 1; in_rob_data = 32'h41;
        io_buffer_full = 1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            in_rob_ce = 0;
            io_buffer_full = (c <= 3);
            #1;
            chk("io_mem_wr", mem_wr, c == 4);
            chk("io_rob_ce", out_rob_ce, c == 5);
            if (c == 4) begin
                chk("io_mem_a", mem_a, 32'h30000);
                chk("io_mem_dout", mem_dout, 8'h41);
            end
        end
        io_buffer_full = 0;
        chk("io_wlog_len", wlog.size(), 1);

        // Misbranch during a load with a pending fetch and a pending store
        clr_mon();
        in_lsb_ce = 1; in_lsb_addr = 32'h100; in_lsb_size = 4; in_lsb_signed = 0;
        step_mon(1);
        in_lsb_ce = 0; in_fetcher_ce = 1; in_fetcher_addr = 32'h10;
        step_mon(2);
        in_fetcher_ce = 0;
        in_rob_ce = 1; in_rob_addr = 32'h300; in_rob_size = 1; in_rob_data = 32'h55;
        step_mon(3);
        in_rob_ce = 0; in_rob_misbranch = 1;
        step_mon(4);
        in_rob_misbranch = 0;
        for (int c = 5; c <= 25; c++) step_mon(c);
        chk("mb_lsb_count", n_l, 0);
        chk("mb_fetch_count", n_f, 0);
        chk("mb_rob_count", n_r, 1);
        chk("mb_rob_t", t_r, 6);
        chk("mb_store_ram", ram[32'h300], 8'h55);
        model_store(32'h300, 32'h55, 1);

        // rdy low for 4 cycles in the middle of a word load
        clr_mon();
        in_lsb_ce = 1; in_lsb_addr = 32'h200; in_lsb_size = 4; in_lsb_signed = 0;
        for (int c = 1; c <= 20; c++) begin
            step_mon(c);
            in_lsb_ce = 0;
            if (c == 2) rdy = 0;
            if (c == 6) rdy = 1;
        end
        chk("rdy_lsb_t", t_l, 10);
        chk("rdy_lsb_count", n_l, 1);
        chk("rdy_lsb_data", out_lsb_data, ref_read(32'h200, 4, 0));

        // Randomized traffic against the reference memory
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            a  = 32'h400 + $urandom_range(0, 255);
            sz = size_tab[$urandom_range(0, 3)];
            sg = 1'($urandom_range(0, 1));
            n  = eff_n(sz);
            case (op)
                0: begin
                    run_read(1, a, sz, sg, d, lat);
                    chk("rnd_fetch_lat", lat, 6);
                    chk("rnd_fetch_data", d, ref_read(a, 4, 0));
                end
                1: begin
                    run_read(0, a, sz, sg, d, lat);
                    chk("rnd_load_lat", lat, n + 2);
                    chk("rnd_load_data", d, ref_read(a, n, sg));
                end
                default: begin
                    d = $urandom;
                    run_write(a, sz, d, lat);
                    chk("rnd_store_lat", lat, n + 1);
                    chk_wlog(a, d, n);
                    model_store(a, d, n);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
